dfu_boot_ctrl: RTL

DFU_BOOT_CTRL -- requirements
Module: dfu_boot_ctrl

---
 rtl/dfu_boot_pkg.sv | 35 +++
 rtl/dfu_boot_timer.sv | 43 ++++
 rtl/dfu_boot_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dfu_boot_pkg.sv
// ============================================================================
// Module      : dfu_boot_pkg
// Description : Shared state encoding, LED codes and DFU constants for the
//               DFU boot controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dfu_boot_pkg;

    typedef enum logic [2:0] {
        S_POR    = 3'd0,
        S_WAIT   = 3'd1,
        S_MANUAL = 3'd2,
        S_QUIET  = 3'd3,
        S_BOOT   = 3'd4
    } state_t;

    localparam logic [1:0] LED_IDLE = 2'd0;
    localparam logic [1:0] LED_PROG = 2'd1;
    localparam logic [1:0] LED_BOOT = 2'd2;

    localparam logic [7:0] DFU_IDLE = 8'h02;

    function automatic logic [1:0] led_decode(input state_t st);
        case (st)
            S_MANUAL:        led_decode = LED_PROG;
            S_QUIET, S_BOOT: led_decode = LED_BOOT;
            default:         led_decode = LED_IDLE;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/dfu_boot_timer.sv
// ============================================================================
// Module      : dfu_boot_timer
// Description : Loadable 32-bit down-counter that saturates at zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dfu_boot_timer #(
    parameter logic [31:0] LOAD_VALUE = 32'd0
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Load wins over decrement; decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VALUE;
        end else if (dec_i && (cnt_q != 32'd0)) begin
            cnt_d = cnt_q - 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= LOAD_VALUE;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 32'd0);

endmodule

`default_nettype wire

// File: rtl/dfu_boot_ctrl.sv
// ============================================================================
// Module      : dfu_boot_ctrl
// Description : DFU bootloader sequencer: core reset hold, auto-boot timeout,
//               manual DFU mode and flash-quiet wait before reconfiguration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dfu_boot_ctrl
    import dfu_boot_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 65535,
    parameter int unsigned BOOT_CYCLES  = 60000000,
    parameter int unsigned QUIET_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] dfu_state,
    input  logic       dfu_detach,
    input  logic       spi_csel,
    output logic       core_reset,
    output logic       boot_now,
    output logic       auto_boot,
    output logic [1:0] led_sel
);

    state_t state_q, state_d;
    logic   auto_boot_q, auto_boot_d;

    logic rst_dec, rst_zero;
    logic boot_load, boot_dec, boot_zero;
    logic quiet_load, quiet_dec, quiet_zero;
    logic host_active;

    assign host_active = (dfu_state > DFU_IDLE);

    dfu_boot_timer #(.LOAD_VALUE(32'(RESET_CYCLES))) u_rst_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (1'b0),
        .dec_i  (rst_dec),
        .zero_o (rst_zero)
    );

    dfu_boot_timer #(.LOAD_VALUE(32'(BOOT_CYCLES))) u_boot_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (boot_load),
        .dec_i  (boot_dec),
        .zero_o (boot_zero)
    );

    dfu_boot_timer #(.LOAD_VALUE(32'(QUIET_CYCLES))) u_quiet_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (quiet_load),
        .dec_i  (quiet_dec),
        .zero_o (quiet_zero)
    );

    always_comb begin
        state_d     = state_q;
        auto_boot_d = auto_boot_q;
        rst_dec     = 1'b0;
        boot_load   = 1'b0;
        boot_dec    = 1'b0;
        quiet_load  = 1'b0;
        quiet_dec   = 1'b0;
        case (state_q)
            S_POR: begin
                if (rst_zero) begin
                    state_d   = S_WAIT;
                    boot_load = 1'b1;
                end else begin
                    rst_dec = 1'b1;
                end
            end
            S_WAIT: begin
                boot_dec = 1'b1;
                // Host activity disarms auto-boot even when detach wins the cycle.
                if (host_active) begin
                    auto_boot_d = 1'b0;
                end
                if (dfu_detach) begin
                    state_d    = S_QUIET;
                    quiet_load = 1'b1;
                end else if (host_active) begin
                    state_d = S_MANUAL;
                end else if (boot_zero) begin
                    state_d    = S_QUIET;
                    quiet_load = 1'b1;
                end
            end
            S_MANUAL: begin
                if (dfu_detach) begin
                    state_d    = S_QUIET;
                    quiet_load = 1'b1;
                end
            end
            S_QUIET: begin
                // Any flash access restarts the quiet window.
                if (!spi_csel) begin
                    quiet_load = 1'b1;
                end else if (quiet_zero) begin
                    state_d = S_BOOT;
                end else begin
                    quiet_dec = 1'b1;
                end
            end
            S_BOOT: begin
                state_d = S_BOOT;
            end
            default: begin
                state_d = S_POR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_POR;
            auto_boot_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            auto_boot_q <= auto_boot_d;
        end
    end

    assign core_reset = (state_q == S_POR);
    assign boot_now   = (state_q == S_BOOT);
    assign auto_boot  = auto_boot_q;
    assign led_sel    = led_decode(state_q);

endmodule

`default_nettype wire
